// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD write-bus receiver.
// Optional busy-timing model is enabled with LCD_BUSY_MODEL_EN.
package lcd_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        BUSY,
        IDLE
    } state_e;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CMD_CLEAR  = 8'h01;
    localparam logic [7:0] CMD_HOME   = 8'h02;
    localparam logic [7:0] CMD_ENTRY  = 8'h04;
    localparam logic [7:0] CMD_CGRAM  = 8'h40;
    localparam logic [7:0] CMD_DDRAM  = 8'h80;
    localparam int         I_D_BIT    = 1;

endpackage

// File: rtl/lcd_strobe_sync.sv
// E-strobe synchroniser, falling-edge detector and RS/DB capture.
module lcd_strobe_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_e_i,
    input  logic       lcd_rs_i,
    input  logic [7:0] lcd_db_i,
    output logic       stb_o,
    output logic       rs_o,
    output logic [7:0] db_o
);

    logic       e_meta_q;
    logic       e_sync_q;
    logic       stb_q;
    logic       rs_q;
    logic [7:0] db_q;
    logic       fall;

    // Edge seen as the synchronised E is about to go low.
    assign fall = e_sync_q & ~e_meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_meta_q <= 1'b0;
            e_sync_q <= 1'b0;
            stb_q    <= 1'b0;
            rs_q     <= 1'b0;
            db_q     <= 8'h00;
        end else begin
            e_meta_q <= lcd_e_i;
            e_sync_q <= e_meta_q;
            stb_q    <= fall;
            if (fall) begin
                rs_q <= lcd_rs_i;
                db_q <= lcd_db_i;
            end
        end
    end

    assign stb_o = stb_q;
    assign rs_o  = rs_q;
    assign db_o  = db_q;

endmodule

// File: rtl/lcd_char_receiver.sv
// Character-LCD bus responder: command decode, DDRAM buffer, cursor, busy.
// Macro LCD_BUSY_MODEL_EN enables the post-command BUSY timing window.
module lcd_char_receiver
    import lcd_pkg::*;
#(
    parameter  int DEPTH        = 32,
    parameter  int BUSY_CYCLES  = 40,
    parameter  int CLEAR_CYCLES = 1600,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lcd_rs,
    input  logic          lcd_e,
    input  logic [7:0]    lcd_db,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] cursor,
    output logic          busy,
    output logic          wr_strobe,
    output logic          cmd_err,
    output logic          overrun
);

    if (CLEAR_CYCLES < DEPTH || BUSY_CYCLES < 1) begin : g_cfg_err
        $error("lcd_char_receiver: bad timing parameters");
    end

`ifdef LCD_BUSY_MODEL_EN
    localparam int CMAX     = (CLEAR_CYCLES > BUSY_CYCLES) ?
                              CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CW       = $clog2(CMAX + 1);
    localparam int CLR_LOAD = CLEAR_CYCLES - DEPTH;
    logic [CW-1:0] cnt_q;
`endif

    state_e        state_q;
    logic [AW-1:0] clr_idx_q;
    logic [AW-1:0] cursor_q;
    logic          incr_q;
    logic          busy_q;
    logic          wr_q;
    logic          err_q;
    logic          ovr_q;
    logic [7:0]    rd_data_q;
    logic [7:0]    mem_q [DEPTH];

    logic          stb;
    logic          rs;
    logic [7:0]    db;

    lcd_strobe_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .lcd_e_i  (lcd_e),
        .lcd_rs_i (lcd_rs),
        .lcd_db_i (lcd_db),
        .stb_o    (stb),
        .rs_o     (rs),
        .db_o     (db)
    );

    // Command class by highest set bit.
    logic cmd_ddram, cmd_cgram, cmd_entry, cmd_home, cmd_clear, cmd_nop;
    assign cmd_ddram = |(db & CMD_DDRAM);
    assign cmd_cgram = !cmd_ddram && |(db & CMD_CGRAM);
    assign cmd_entry = (db[7:3] == 5'd0) && |(db & CMD_ENTRY);
    assign cmd_home  = (db[7:2] == 6'd0) && |(db & CMD_HOME);
    assign cmd_clear = (db == CMD_CLEAR);
    assign cmd_nop   = (db == 8'h00);

    logic          we;
    logic [AW-1:0] wa;
    logic [7:0]    wd;

    always_comb begin
        we = 1'b0;
        wa = cursor_q;
        wd = db;
        if (state_q == CLEAR) begin
            we = 1'b1;
            wa = clr_idx_q;
            wd = CHAR_SPACE;
        end else if (state_q == IDLE && stb && rs) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wa] <= wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            cursor_q  <= '0;
            incr_q    <= 1'b1;
            busy_q    <= 1'b1;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
            rd_data_q <= 8'h00;
`ifdef LCD_BUSY_MODEL_EN
            cnt_q     <= '0;
`endif
        end else begin
            rd_data_q <= mem_q[rd_addr];
            wr_q      <= 1'b0;
            if (stb && state_q != IDLE) begin
                ovr_q <= 1'b1;
            end
            unique case (state_q)
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + AW'(1);
                    if (clr_idx_q == AW'(DEPTH - 1)) begin
`ifdef LCD_BUSY_MODEL_EN
                        if (CLR_LOAD == 0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CW'(CLR_LOAD);
                        end
`else
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
`endif
                    end
                end
`ifdef LCD_BUSY_MODEL_EN
                BUSY: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
`endif
                IDLE: begin
                    if (stb) begin
                        if (rs) begin
                            wr_q     <= 1'b1;
                            cursor_q <= incr_q ? cursor_q + AW'(1)
                                               : cursor_q - AW'(1);
                        end else if (cmd_clear) begin
                            cursor_q  <= '0;
                            incr_q    <= 1'b1;
                            clr_idx_q <= '0;
                            state_q   <= CLEAR;
                            busy_q    <= 1'b1;
                        end else begin
                            if (cmd_ddram) cursor_q <= db[AW-1:0];
                            if (cmd_cgram) err_q    <= 1'b1;
                            if (cmd_entry) incr_q   <= db[I_D_BIT];
                            if (cmd_home)  cursor_q <= '0;
                        end
`ifdef LCD_BUSY_MODEL_EN
                        if (rs || (!cmd_clear && !cmd_nop)) begin
                            state_q <= BUSY;
                            busy_q  <= 1'b1;
                            cnt_q   <= CW'(BUSY_CYCLES);
                        end
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data   = rd_data_q;
    assign cursor    = cursor_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_q;
    assign cmd_err   = err_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_lcd_char_receiver.sv
// Directed bench for lcd_char_receiver with write-cursor scoreboard.
module tb_lcd_char_receiver;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
`ifdef LCD_BUSY_MODEL_EN
    localparam int EXP_CLR = 1600;
    localparam bit BUSY_EN = 1'b1;
`else
    localparam int EXP_CLR = DEPTH;
    localparam bit BUSY_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lcd_rs = 1'b0;
    logic          lcd_e = 1'b0;
    logic [7:0]    lcd_db = 8'h00;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic [AW-1:0] cursor;
    logic          busy;
    logic          wr_strobe;
    logic          cmd_err;
    logic          overrun;

    int vectors = 0;
    int miscompares = 0;
    int n_wr = 0;
    logic [AW-1:0] exp_q [$];

    lcd_char_receiver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lcd_rs    (lcd_rs),
        .lcd_e     (lcd_e),
        .lcd_db    (lcd_db),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .cursor    (cursor),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .cmd_err   (cmd_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wr_strobe === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0)
                check("wr_unexpected", exp_q.size(), 1);
            else
                check("wr_cursor", cursor, exp_q.pop_front());
        end
    end

    task automatic strobe(input logic rs, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs;
        lcd_db = d;
        lcd_e  = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic send(input logic rs, input logic [7:0] d);
        strobe(rs, d);
        wait_idle("idle");
    endtask

    task automatic put(input logic [7:0] d, input logic [AW-1:0] nc);
        exp_q.push_back(nc);
        send(1'b1, d);
    endtask

    task automatic rd_chk(input int a, input logic [7:0] exp,
                          input string tag);
        @(negedge clk);
        rd_addr = AW'(a);
        @(negedge clk);
        check(tag, rd_data, exp);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_cursor", cursor, 0);
        check("rst_wr", wr_strobe, 0);
        check("rst_err", cmd_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_rd", rd_data, 0);

        rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy !== 1'b0 && n < 5000);
        check("clr_time", n, EXP_CLR);
        for (int i = 0; i < DEPTH; i++) rd_chk(i, 8'h20, "por_space");
        check("por_cursor", cursor, 0);

        put(8'h48, 5'd1);
        put(8'h49, 5'd2);
        rd_chk(0, 8'h48, "buf0_H");
        rd_chk(1, 8'h49, "buf1_I");
        check("cursor_2", cursor, 2);
        check("two_strobes", n_wr, 2);

        send(1'b0, 8'h9F);
        check("ddram_31", cursor, 31);
        put(8'h41, 5'd0);
        put(8'h42, 5'd1);
        rd_chk(31, 8'h41, "buf31");
        rd_chk(0, 8'h42, "buf0_wrap");

        send(1'b0, 8'h04);
        send(1'b0, 8'h80);
        put(8'h5A, 5'd31);
        rd_chk(0, 8'h5A, "buf0_dec");
        check("dec_wrap", cursor, 31);

        send(1'b0, 8'h06);
        send(1'b0, 8'h83);
        check("ddram_3", cursor, 3);
        exp_q.push_back(5'd4);
        if (!BUSY_EN) exp_q.push_back(5'd5);
        strobe(1'b1, 8'h41);
        strobe(1'b1, 8'h42);
        wait_idle("ovr_idle");
        check("overrun", overrun, BUSY_EN ? 1 : 0);
        check("ovr_cursor", cursor, BUSY_EN ? 4 : 5);
        rd_chk(3, 8'h41, "ovr_buf3");
        rd_chk(4, BUSY_EN ? 8'h20 : 8'h42, "ovr_buf4");

        send(1'b0, 8'h45);
        check("cmd_err", cmd_err, 1);
        check("err_cursor", cursor, BUSY_EN ? 4 : 5);
        rd_chk(3, 8'h41, "err_buf3");
        send(1'b0, 8'h02);
        check("home", cursor, 0);
        rd_chk(0, 8'h5A, "home_buf0");

        send(1'b0, 8'h04);
        send(1'b0, 8'h01);
        for (int i = 0; i < DEPTH; i++) rd_chk(i, 8'h20, "clr_space");
        check("clr_cursor", cursor, 0);
        check("err_sticky", cmd_err, 1);
        put(8'h33, 5'd1);
        check("clr_incr", cursor, 1);
        rd_chk(0, 8'h33, "clr_buf0");

        repeat (4) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        check("n_writes", n_wr, BUSY_EN ? 7 : 8);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_char_receiver.md
Name: lcd_char_receiver

Overview:
- Display-side responder for the character-LCD write bus (RS, E, DB[7:0]) driven by the processor's LCD output stage.
- Samples each E falling edge and decodes the byte as a command (RS=0) or a character (RS=1).
- Maintains a DDRAM-style character buffer with cursor and busy timing.
- Exposes a synchronous read port so the testbench or debug logic can inspect displayed text.

Parameters:
- DEPTH, 32: character buffer entries; power of two; AW = $clog2(DEPTH).
- BUSY_CYCLES, 40: busy window after any accepted non-clear command or character write.
- CLEAR_CYCLES, 1600: busy window after a clear; must be >= DEPTH.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- lcd_rs  in  1  register select: 0 = command, 1 = data
- lcd_e  in  1  enable strobe; byte latched on falling edge (asynchronous to clk)
- lcd_db  in  8  data bus; stable while lcd_e high and for at least 2 clk after its fall
- rd_addr  in  AW  buffer read address
- rd_data  out  8  buffer[rd_addr]; registered, 1-cycle latency
- cursor  out  AW  current DDRAM address
- busy  out  1  high while executing; strobes arriving while high are dropped
- wr_strobe  out  1  one-cycle pulse when a character is written
- cmd_err  out  1  sticky; set by an unsupported command (CGRAM set, 0x40-0x7F)
- overrun  out  1  sticky; set by a strobe arriving while busy

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Input synchronisation: lcd_e passes through a 2-flop synchroniser. A falling edge is detected on the synchronised E. lcd_rs and lcd_db are captured in the same cycle the edge is detected.
- Reset values: cursor=0, incr=1, busy=1, wr_strobe=0, cmd_err=0, overrun=0, rd_data=0, state=CLEAR, clr_idx=0.
- Reset behaviour: on reset release, the block runs a power-on clear. Reset asserted mid-operation aborts the operation and restarts the clear.
- States: CLEAR, BUSY, IDLE.
- CLEAR:
  - Writes 0x20 to buffer[clr_idx], one entry per cycle, clr_idx 0..DEPTH-1.
  - Loads the busy counter with CLEAR_CYCLES-DEPTH (power-on clear included).
  - Goes to BUSY; goes directly to IDLE if that count is 0.
- BUSY: decrements the counter; goes to IDLE when it reaches 0. busy=0 only in IDLE.
- IDLE: on a detected falling edge, decodes the captured byte. Decode takes 1 cycle from edge detect, so effects are visible 3-4 clk after the physical E fall.
- RS=1 (character write):
  - buffer[cursor]=db; wr_strobe pulses 1 cycle.
  - cursor = cursor+1 if incr=1, else cursor-1; wraps modulo DEPTH in both directions (DEPTH-1+1 -> 0, 0-1 -> DEPTH-1).
  - Goes to BUSY with BUSY_CYCLES.
- RS=0 (command), decoded by highest set bit:
  - 0x00: no-op; no busy window.
  - 0x01: clear; cursor=0, incr=1; goes to CLEAR.
  - 0x02-0x03: home; cursor=0; buffer unchanged.
  - 0x04-0x07: entry mode; incr=db[1]. db[0] (display shift) is ignored.
  - 0x08-0x3F: display control, shift and function set; accepted, no state effect.
  - 0x40-0x7F: cmd_err=1; otherwise ignored.
  - 0x80-0xFF: cursor = db[6:0] modulo DEPTH.
  - Every non-clear, non-zero command goes to BUSY with BUSY_CYCLES.
- Strobe detected while not in IDLE: byte discarded, overrun=1, no other effect.
- Read port: rd_data registered every cycle from buffer[rd_addr], independent of state. A read colliding with a same-cycle write returns the old value.

Optional Feature:
- Macro: LCD_BUSY_MODEL_EN.
- Defined: timing exactly as above.
- Undefined:
  - BUSY state removed; character writes and non-clear commands return straight to IDLE.
  - busy is high only during CLEAR (DEPTH cycles), so overrun can only set during CLEAR.
  - BUSY_CYCLES and CLEAR_CYCLES are unused.

Decomposition:
- lcd_pkg holds:
  - state enum {CLEAR, BUSY, IDLE}
  - CHAR_SPACE = 8'h20
  - command mask constants: CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_CGRAM, CMD_DDRAM
  - entry-mode bit index I_D_BIT = 1
- One sub-module: lcd_strobe_sync. It contains the 2-flop E synchroniser, falling-edge detector and RS/DB capture register, and outputs a one-cycle strobe plus the captured rs and db.

Test Plan:
- Reset, wait DEPTH+CLEAR_CYCLES cycles, read all addresses -> every rd_data=0x20; busy falls to 0 exactly CLEAR_CYCLES cycles after reset release; cursor=0.
- Write 'H','I' (RS=1, 0x48, 0x49) with gaps > BUSY_CYCLES -> buffer[0]=0x48, buffer[1]=0x49, cursor=2, two wr_strobe pulses.
- Command 0x9F then write 0x41, then 0x42 -> buffer[31]=0x41, cursor wraps to 0, buffer[0]=0x42.
- Command 0x04 (decrement), 0x80, then write 0x5A -> buffer[0]=0x5A, cursor=31.
- Write 0x41, then strobe 0x42 within 10 cycles -> 0x42 dropped, overrun=1, cursor advanced once. Without LCD_BUSY_MODEL_EN -> both written, overrun=0.
- Command 0x45 -> cmd_err=1, cursor and buffer unchanged. Then 0x01 -> all entries 0x20, cursor=0, cmd_err stays 1.
